lfsr_msg_encrypter: RTL and testbench

Hardware encryption engine for the LFSR message-cipher flow. It is the transmitter side of the decrypt/depad program. It reads a plaintext message and key material from the shared data memory. It prepends a preamble of ASCII-space padding, subtracts 0x20 from each character, XORs it with a 7-bit Fibonacci LFSR and writes 64 ciphertext bytes back to data memory. It sits beside `top_level` on the same single-port data-memory bus and uses the same req/ack handshake.

---
 rtl/lfsr_msg_encrypter.sv | 268 ++++++++++++++++++++++++++
 tb/tb_lfsr_msg_encrypter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_msg_encrypter.sv
//
// lfsr_msg_encrypter
// ------------------
// Transmitter half of the LFSR message cipher. The engine reads three
// configuration bytes and a plaintext message from a shared single-port data
// memory. It writes N_CHARS ciphertext bytes back to that memory.
//
// Each ciphertext byte is built like this:
//   - p is 0x20 (ASCII space) for the first `pre` characters, which form the
//     preamble. After that, p is message byte i-pre.
//   - c[6:0] = (p - 0x20)[6:0] ^ lfsr
//   - c[7]   = even parity of c[6:0] when the parity build is selected,
//              and 0 otherwise.
//   - lfsr then advances as a Fibonacci LFSR:
//     lfsr <= {lfsr[5:0], ^(lfsr & taps)}
//
// Memory map (default parameters):
//   CFG_BASE+0 : pre_length. The low nibble is clamped to PRE_MIN..PRE_MAX.
//   CFG_BASE+1 : taps [6:0]
//   CFG_BASE+2 : LFSR seed [6:0]. A seed of 0 is replaced by 7'h01.
//   CT_BASE+i  : ciphertext byte i
//
// Build option:
//   LFSR_ENC_PARITY_EN - when defined, c[7] carries even parity over c[6:0].
//                        When undefined, c[7] is 0 and no parity tree exists.
//
// Ports:
//   clk          in   single clock; every flop updates on its rising edge
//   init_n       in   asynchronous active-low reset
//   req          in   launch request; only a rising edge (req=1, req_q=0)
//                     starts a run, and only from IDLE or DONE
//   ack          out  registered; high while the engine sits in DONE
//   mem_addr     out  data-memory address (combinational from state)
//   mem_rd_data  in   registered read data, valid the cycle after mem_addr
//   mem_wr_en    out  write strobe, high only in ENC_WR
//   mem_wr_data  out  write data, non-zero only in ENC_WR
//
// Handshake: the memory bus has no ready/valid pair. A read address is
// presented for one cycle and its data is consumed in the following cycle.
// A write is presented for one cycle with mem_wr_en=1, and the memory
// captures it on the next rising edge. req/ack is a level handshake in which
// only the rising edge of req is meaningful.

module lfsr_msg_encrypter #(
    parameter int CFG_BASE = 61,
    parameter int CT_BASE  = 64,
    parameter int N_CHARS  = 64,
    parameter int PRE_MIN  = 10,
    parameter int PRE_MAX  = 15
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic       req,
    output logic       ack,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [7:0] CFG_ADDR_PRE  = 8'(CFG_BASE);
    localparam logic [7:0] CFG_ADDR_TAPS = 8'(CFG_BASE + 1);
    localparam logic [7:0] CFG_ADDR_SEED = 8'(CFG_BASE + 2);
    localparam logic [7:0] CT_ADDR_BASE  = 8'(CT_BASE);
    localparam logic [6:0] LAST_CHAR     = 7'(N_CHARS - 1);

    // The clamp compares at 8 bits so that PRE_MAX=15 is still a real
    // comparison against the zero-extended nibble.
    localparam logic [7:0] PRE_MIN_W = 8'(PRE_MIN);
    localparam logic [7:0] PRE_MAX_W = 8'(PRE_MAX);
    localparam logic [3:0] PRE_MIN_N = 4'(PRE_MIN);
    localparam logic [3:0] PRE_MAX_N = 4'(PRE_MAX);

    localparam logic [6:0] SPACE_7 = 7'h20;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CFG0   = 3'd1,
        CFG1   = 3'd2,
        CFG2   = 3'd3,
        CFG3   = 3'd4,
        ENC_RD = 3'd5,
        ENC_WR = 3'd6,
        DONE   = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic       req_q,   req_d;
    logic       ack_q,   ack_d;
    logic [3:0] pre_q,   pre_d;
    logic [6:0] taps_q,  taps_d;
    logic [6:0] lfsr_q,  lfsr_d;
    logic [6:0] i_q,     i_d;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic       req_rise;
    logic [7:0] pre_raw;
    logic [3:0] pre_clamped;
    logic [6:0] seed_fixed;
    logic       in_preamble;
    logic [6:0] plain_7;
    logic [6:0] cipher_7;
    logic       cipher_msb;
    logic       lfsr_fb;
    logic [7:0] rd_addr;
    logic [7:0] wr_addr;

    // Bit 7 of the read data never feeds the cipher. The 7-bit subtract
    // below already equals the low 7 bits of the 8-bit subtract.
    logic       unused_rd_msb;
    assign unused_rd_msb = mem_rd_data[7];

    assign req_rise = req & ~req_q;

    always_comb begin
        pre_raw     = {4'b0000, mem_rd_data[3:0]};
        pre_clamped = mem_rd_data[3:0];
        if (pre_raw < PRE_MIN_W) begin
            pre_clamped = PRE_MIN_N;
        end else if (pre_raw > PRE_MAX_W) begin
            pre_clamped = PRE_MAX_N;
        end
    end

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    assign seed_fixed = (mem_rd_data[6:0] == 7'h00) ? 7'h01 : mem_rd_data[6:0];

    assign in_preamble = (i_q < {3'b000, pre_q});

    // The read address is only meaningful once i >= pre. In the preamble it
    // wraps, and the data it returns is ignored.
    assign rd_addr = {1'b0, i_q} - {4'b0000, pre_q};
    assign wr_addr = CT_ADDR_BASE + {1'b0, i_q};

    always_comb begin
        plain_7  = in_preamble ? SPACE_7 : mem_rd_data[6:0];
        cipher_7 = (plain_7 - SPACE_7) ^ lfsr_q;
`ifdef LFSR_ENC_PARITY_EN
        cipher_msb = ^cipher_7;
`else
        cipher_msb = 1'b0;
`endif
    end

    assign lfsr_fb = ^(lfsr_q & taps_q);

    // ------------------------------------------------------------------
    // Process 1: state and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            pre_q   <= 4'h0;
            taps_q  <= 7'h00;
            lfsr_q  <= 7'h00;
            i_q     <= 7'h00;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            pre_q   <= pre_d;
            taps_q  <= taps_d;
            lfsr_q  <= lfsr_d;
            i_q     <= i_d;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next state and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        req_d   = req;
        pre_d   = pre_q;
        taps_d  = taps_q;
        lfsr_d  = lfsr_q;
        i_d     = i_q;

        unique case (state_q)
            IDLE: begin
                if (req_rise) state_d = CFG0;
            end
            CFG0: begin
                state_d = CFG1;
            end
            CFG1: begin
                pre_d   = pre_clamped;
                state_d = CFG2;
            end
            CFG2: begin
                taps_d  = mem_rd_data[6:0];
                state_d = CFG3;
            end
            CFG3: begin
                lfsr_d  = seed_fixed;
                i_d     = 7'h00;
                state_d = ENC_RD;
            end
            ENC_RD: begin
                state_d = ENC_WR;
            end
            ENC_WR: begin
                lfsr_d  = {lfsr_q[5:0], lfsr_fb};
                i_d     = i_q + 7'h01;
                state_d = (i_q == LAST_CHAR) ? DONE : ENC_RD;
            end
            DONE: begin
                if (req_rise) state_d = CFG0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // ack is registered from the next state. It therefore rises on the
        // same edge that enters DONE and falls on the edge that leaves it.
        ack_d = (state_d == DONE);
    end

    // ------------------------------------------------------------------
    // Process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr    = 8'h00;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'h00;

        unique case (state_q)
            CFG0:    mem_addr = CFG_ADDR_PRE;
            CFG1:    mem_addr = CFG_ADDR_TAPS;
            CFG2:    mem_addr = CFG_ADDR_SEED;
            ENC_RD:  mem_addr = rd_addr;
            ENC_WR: begin
                mem_addr    = wr_addr;
                mem_wr_en   = 1'b1;
                mem_wr_data = {cipher_msb, cipher_7};
            end
            default: mem_addr = 8'h00;
        endcase
    end

    assign ack = ack_q;

`ifndef SYNTHESIS
    // The message area below CT_BASE must never be overwritten.
    wr_addr_in_ct_area: assert property (
        @(posedge clk) disable iff (!init_n)
        mem_wr_en |-> (mem_addr >= CT_ADDR_BASE)
    );

    // ack and a write strobe can never coexist.
    ack_excludes_write: assert property (
        @(posedge clk) disable iff (!init_n)
        ack |-> !mem_wr_en
    );
`endif

endmodule

// File: tb/tb_lfsr_msg_encrypter.sv
//
// Testbench for lfsr_msg_encrypter.
// The bench contains a behavioural registered-read memory, a scoreboard queue
// of expected {addr, data} writes filled from a software model, a table of
// configurations, and hand-written sequences for reset and handshake cases.

module tb_lfsr_msg_encrypter;

`ifdef LFSR_ENC_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       init_n = 1'b0;
    logic       req = 1'b0;
    logic       ack;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    always #5 clk = ~clk;

    lfsr_msg_encrypter dut (
        .clk         (clk),
        .init_n      (init_n),
        .req         (req),
        .ack         (ack),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    // Behavioural data memory. Bench loads enter through a side port so that
    // the array has a single writing process.
    logic [7:0] mem [256];
    logic       tb_we = 1'b0;
    logic [7:0] tb_wa = 8'h00;
    logic [7:0] tb_wd = 8'h00;

    always @(posedge clk) begin
        mem_rd_data <= mem[mem_addr];
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        else if (tb_we) mem[tb_wa] <= tb_wd;
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int          total = 0;
    int          bad = 0;
    int          wr_cnt = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  exp_ct [64];
    logic [7:0]  snap [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (init_n && mem_wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr %0h data %0h, expected no write", mem_addr, mem_wr_data);
            end else begin
                check("ct_write", {16'h0, mem_addr, mem_wr_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    // Software model: computes the 64 ciphertext bytes from the current
    // memory image and queues the expected writes.
    task automatic model_push();
        logic [3:0] pre;
        logic [6:0] lf, tp, c7;
        logic [7:0] p, d;
        logic       fb;
        pre = mem[61][3:0];
        if (pre < 4'd10) pre = 4'd10;
        tp = mem[62][6:0];
        lf = mem[63][6:0];
        if (lf == 7'h00) lf = 7'h01;
        for (int k = 0; k < 64; k++) begin
            if (k < int'(pre)) p = 8'h20;
            else p = mem[k - int'(pre)];
            d  = p - 8'h20;
            c7 = d[6:0] ^ lf;
            exp_ct[k] = {(PAR ? ^c7 : 1'b0), c7};
            exp_q.push_back({8'(64 + k), exp_ct[k]});
            fb = ^(lf & tp);
            lf = {lf[5:0], fb};
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        tb_wa = a;
        tb_wd = d;
        tb_we = 1'b1;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic load_cfg(input logic [7:0] pre_raw, input logic [7:0] taps,
                            input logic [7:0] seed, input int kind);
        string s;
        s = "Mr. Watson, come here. I want to see you.";
        for (int k = 0; k < 61; k++) begin
            if (kind == 0) poke(8'(k), (k < s.len()) ? s[k] : 8'h20);
            else if (kind == 1 && k == 0) poke(8'h00, 8'h41);
            else poke(8'(k), 8'($urandom_range(0, 255)));
        end
        poke(8'd61, pre_raw);
        poke(8'd62, taps);
        poke(8'd63, seed);
        for (int k = 64; k < 128; k++) poke(8'(k), 8'hEE);
    endtask

    // Launch with a clean req rising edge. lat is the index of the first edge
    // after which ack reads high, where edge 1 samples the req rise.
    task automatic run_req(input int pulse_at, output int lat);
        @(negedge clk) req = 1'b0;
        @(negedge clk) req = 1'b1;
        lat = -1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) check("ack_low_after_launch", {31'h0, ack}, 32'h0);
            if (pulse_at > 0) begin
                if (n == pulse_at)     req = 1'b0;
                if (n == pulse_at + 2) req = 1'b1;
                if (n == pulse_at + 4) req = 1'b0;
            end
            if (ack) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic full_run(input int pulse_at);
        int base;
        int lat;
        model_push();
        base = wr_cnt;
        run_req(pulse_at, lat);
        check("ack_latency", lat, 133);
        check("write_count", wr_cnt - base, 64);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] pre_raw;
        logic [7:0] taps;
        logic [7:0] seed;
        int         kind;      // 0 message text, 1 DM[0]=0x41 + random, 2 random
        int         chk_addr;  // 0 means no spot check
        logic [7:0] chk_val;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int base;
        int diffs;
        int n;

        vecs[0] = '{8'h0A, 8'h60, 8'h01, 0, 74, 8'h35};
        vecs[1] = '{8'h03, 8'h60, 8'h00, 0, 70, 8'h41};
        vecs[2] = '{8'h0F, 8'h60, 8'h01, 1, 79, 8'h2B};
        vecs[3] = '{8'hFC, 8'hB8, 8'h80, 2, 64, (PAR ? 8'h81 : 8'h01)};
        vecs[4] = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 2, 0, 8'h00};
        vecs[5] = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 2, 0, 8'h00};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_wr_en", {31'h0, mem_wr_en}, 32'h0);
        check("rst_addr", {24'h0, mem_addr}, 32'h0);
        check("rst_wr_data", {24'h0, mem_wr_data}, 32'h0);
        check("rst_state", int'(dut.state_q), 0);
        @(negedge clk) init_n = 1'b1;

        // Table-driven runs
        for (int v = 0; v < 6; v++) begin
            load_cfg(vecs[v].pre_raw, vecs[v].taps, vecs[v].seed, vecs[v].kind);
            full_run(0);
            if (vecs[v].chk_addr != 0)
                check("spot_byte", {24'h0, mem[vecs[v].chk_addr]}, {24'h0, vecs[v].chk_val});
            if (v == 0) begin
                check("dm64", {24'h0, mem[64]}, {24'h0, (PAR ? 8'h81 : 8'h01)});
                check("dm65", {24'h0, mem[65]}, {24'h0, (PAR ? 8'h82 : 8'h02)});
                check("dm69", {24'h0, mem[69]}, {24'h0, (PAR ? 8'hA0 : 8'h20)});
                check("dm70", {24'h0, mem[70]}, 32'h41);
                for (int k = 0; k < 64; k++) snap[k] = mem[64 + k];
            end
            if (v == 1) begin
                diffs = 0;
                for (int k = 0; k < 64; k++) if (mem[64 + k] !== snap[k]) diffs++;
                check("clamp_zero_seed_same_as_ref", diffs, 0);
            end
        end

        // req held high through DONE: no restart.
        base = wr_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("hold_req_ack", {31'h0, ack}, 32'h1);
        check("hold_req_no_writes", wr_cnt - base, 0);

        // req rise in DONE: restart gives the same ciphertext.
        for (int k = 0; k < 64; k++) snap[k] = mem[64 + k];
        full_run(0);
        diffs = 0;
        for (int k = 0; k < 64; k++) if (mem[64 + k] !== snap[k]) diffs++;
        check("restart_same_ct", diffs, 0);

        // req pulse during ENC is ignored.
        full_run(30);

        // Reset mid-run after the 20th write.
        @(negedge clk) req = 1'b0;
        load_cfg(vecs[0].pre_raw, vecs[0].taps, vecs[0].seed, vecs[0].kind);
        model_push();
        base = wr_cnt;
        @(negedge clk) req = 1'b1;
        n = 0;
        while (wr_cnt - base < 20 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("writes_before_reset", wr_cnt - base, 20);
        @(posedge clk);
        #2 init_n = 1'b0;
        #1;
        check("midrst_ack", {31'h0, ack}, 32'h0);
        check("midrst_wr_en", {31'h0, mem_wr_en}, 32'h0);
        check("midrst_state", int'(dut.state_q), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        req = 1'b0;
        check("midrst_last_written", {24'h0, mem[83]}, {24'h0, exp_ct[19]});
        diffs = 0;
        for (int k = 84; k < 128; k++) if (mem[k] !== 8'hEE) diffs++;
        check("midrst_untouched_tail", diffs, 0);
        check("midrst_write_total", wr_cnt - base, 20);
        @(negedge clk) init_n = 1'b1;
        full_run(0);
        check("after_reset_dm74", {24'h0, mem[74]}, 32'h35);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected test end");
        $fatal(1, "watchdog");
    end

endmodule
